// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter/sequencer for the shared combinational alu
// Optional feature macro ALU_ARB_FIXED_PRIO_EN: fixed priority (port 0 first) instead of round-robin.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [2*SEL_W-1:0] req_sel,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [SEL_W-1:0]   alu_sel,
  input  logic               alu_c,
  input  logic [WIDTH-1:0]   alu_out1,
  input  logic [WIDTH-1:0]   alu_out2,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic               rsp_c,
  output logic [WIDTH-1:0]   rsp_out1,
  output logic [WIDTH-1:0]   rsp_out2,
  output logic               rsp_err
);

  localparam logic [SEL_W-1:0] SEL_DIV = SEL_W'(3);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state, state_nxt;
  logic             gnt;
  logic             accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [SEL_W-1:0] sel_op;
  logic             div_zero;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb gnt = ~req_valid[0];
`else
  logic last_grant;

  // Contention goes to the port that did not win last; a lone requester always wins.
  always_comb begin
    if (req_valid == 2'b11) gnt = ~last_grant;
    else                    gnt = ~req_valid[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= gnt;
  end
`endif

  always_comb begin
    sel_a    = gnt ? req_a[2*WIDTH-1:WIDTH]   : req_a[WIDTH-1:0];
    sel_b    = gnt ? req_b[2*WIDTH-1:WIDTH]   : req_b[WIDTH-1:0];
    sel_op   = gnt ? req_sel[2*SEL_W-1:SEL_W] : req_sel[SEL_W-1:0];
    div_zero = (sel_op == SEL_DIV) && (sel_b == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = div_zero ? RESP : ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is gated by rst so outputs read zero while reset is held.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    if (state == IDLE && !rst) req_ready = req_valid & (gnt ? 2'b10 : 2'b01);
    if (state == RESP)         rsp_valid = 1'b1;
    accept = |(req_valid & req_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      rsp_id   <= 1'b0;
      rsp_c    <= 1'b0;
      rsp_out1 <= '0;
      rsp_out2 <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        alu_a   <= sel_a;
        alu_b   <= sel_b;
        alu_sel <= sel_op;
        rsp_id  <= gnt;
        if (div_zero) begin
          rsp_err  <= 1'b1;
          rsp_c    <= 1'b0;
          rsp_out1 <= '0;
          rsp_out2 <= '0;
        end
      end
      if (state == ISSUE) begin
        rsp_c    <= alu_c;
        rsp_out1 <= alu_out1;
        rsp_out2 <= alu_out2;
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed bench for alu_arbiter against a transaction-level model
// Honours ALU_ARB_FIXED_PRIO_EN in the reference grant rule.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [7:0] req_a = '0, req_b = '0, req_sel = '0;
  logic [3:0] alu_a, alu_b, alu_sel, alu_out1, alu_out2;
  logic       alu_c;
  logic       rsp_valid, rsp_id, rsp_c, rsp_err;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_out1, rsp_out2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(4), .SEL_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_c(alu_c), .alu_out1(alu_out1), .alu_out2(alu_out2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_out1(rsp_out1), .rsp_out2(rsp_out2), .rsp_err(rsp_err)
  );

  // Stand-in alu; result packed as {c, out2, out1}.
  function automatic logic [8:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    logic [8:0] r;
    logic [4:0] t;
    logic [7:0] p;
    r = '0;
    case (s)
      4'd0: begin t = {1'b0, a} + {1'b0, b}; r = {t[4], 4'b0, t[3:0]}; end
      4'd1: begin t = {1'b0, a} - {1'b0, b}; r = {t[4], 4'b0, t[3:0]}; end
      4'd2: begin p = {4'b0, a} * {4'b0, b}; r = {1'b0, p}; end
      4'd3: if (b != 4'd0) r = {1'b0, a % b, a / b};
      default: r = {^(a | b), a & b, a ^ b};
    endcase
    return r;
  endfunction

  always_comb {alu_c, alu_out2, alu_out1} = alu_fn(alu_a, alu_b, alu_sel);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: one outstanding op, response due at a known cycle.
  bit          busy;
  int          rsp_at, cyc;
  bit          m_last;
  logic [10:0] e_rsp;
  logic [11:0] e_op;
  int          acc_port;
  bit          s_rv;
  logic [1:0]  s_rdy;
  logic [10:0] s_rsp;
  logic [3:0]  s_alusel;
  bit          keep, rand_on;

  function automatic int pick(input logic [1:0] v);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v[0] ? 0 : 1;
`else
    if (v == 2'b11) return m_last ? 0 : 1;
    return v[0] ? 0 : 1;
`endif
  endfunction

  task automatic m_reset();
    busy = 0; m_last = 1'b1; e_op = '0; e_rsp = '0; cyc = 0; rsp_at = 0;
  endtask

  task automatic set_req(input int p, input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    req_a[p*4 +: 4] = a; req_b[p*4 +: 4] = b; req_sel[p*4 +: 4] = s; req_valid[p] = 1'b1;
  endtask

  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i]) begin
        if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        set_req(i, 4'($urandom), ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom), 4'($urandom_range(0, 5)));
      end
    end
    rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic tick();
    logic [1:0] er;
    int         g;
    logic [3:0] a, b, s;
    logic [8:0] r;
    bit         err, due;
    @(negedge clk);
    g  = pick(req_valid);
    er = 2'b00;
    if (!busy && req_valid != 2'b00) er[g] = 1'b1;
    due      = busy && (cyc >= rsp_at);
    s_rdy    = req_ready;
    s_rv     = rsp_valid;
    s_rsp    = {rsp_id, rsp_c, rsp_out1, rsp_out2, rsp_err};
    s_alusel = alu_sel;
    check("req_ready", 32'(req_ready), 32'(er));
    check("rsp_valid", 32'(rsp_valid), 32'(due));
    if (due) check("rsp_fields", 32'(s_rsp), 32'(e_rsp));
    check("alu_ops", 32'({alu_a, alu_b, alu_sel}), 32'(e_op));
    acc_port = -1;
    if (busy) begin
      if (due && rsp_ready) busy = 0;
    end else if (req_valid != 2'b00) begin
      acc_port = g;
      m_last   = g[0];
      a = req_a[g*4 +: 4]; b = req_b[g*4 +: 4]; s = req_sel[g*4 +: 4];
      err   = (s == 4'd3) && (b == 4'd0);
      r     = alu_fn(a, b, s);
      e_op  = {a, b, s};
      e_rsp = err ? {g[0], 9'b0, 1'b1} : {g[0], r[8], r[3:0], r[7:4], 1'b0};
      busy   = 1;
      rsp_at = cyc + (err ? 1 : 2);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (acc_port >= 0 && !keep) req_valid[acc_port] = 1'b0;
    if (rand_on) drive_random();
  endtask

  task automatic wait_rsp(output int lat);
    int t_acc = -1;
    lat = -1;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (s_rv) begin
        lat = t - t_acc;
        break;
      end
      if (acc_port >= 0) t_acc = t;
    end
    if (lat < 0) check("rsp_timeout", 32'(s_rv), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  int          lat;
  int          order[$];
  int          times[$];
  logic [10:0] hold;

  initial begin
    keep = 0; rand_on = 0;
    m_reset();
    #1 rst = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_id, rsp_c, rsp_out1, rsp_out2, rsp_err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();

    // single add on port 0
    set_req(0, 4'b0011, 4'b0100, 4'b0000);
    rsp_ready = 1'b1;
    wait_rsp(lat);
    check("add_latency", 32'(lat), 32'd2);
    check("add_rsp", 32'(s_rsp), 32'({1'b0, 1'b0, 4'b0111, 4'b0000, 1'b0}));

    // both ports requesting continuously
    do_reset();
    keep = 1;
    set_req(0, 4'b0011, 4'b0100, 4'b0000);
    set_req(1, 4'b0101, 4'b0001, 4'b0001);
    rsp_ready = 1'b1;
    for (int t = 0; t < 40 && order.size() < 4; t++) begin
      tick();
      if (acc_port >= 0) begin
        order.push_back(acc_port);
        times.push_back(t);
      end
      if (s_rv && s_rsp[10]) check("rr_p1_out1", 32'(s_rsp[8:5]), 32'd4);
    end
    check("rr_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("grant_order", 32'(order[i]), 32'd0);
`else
      check("grant_order", 32'(order[i]), 32'(i % 2));
`endif
      if (i > 0) check("grant_spacing", 32'(times[i] - times[i-1]), 32'd3);
    end
    keep = 0;
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) tick();

    // divide by zero on port 1
    set_req(1, 4'b1001, 4'b0000, 4'b0011);
    wait_rsp(lat);
    check("div0_latency", 32'(lat), 32'd1);
    check("div0_rsp", 32'(s_rsp), 32'({1'b1, 9'b0, 1'b1}));
    check("div0_alu_sel", 32'(s_alusel), 32'd3);

    // backpressure with a pending requester on port 1
    rsp_ready = 1'b0;
    set_req(0, 4'b0010, 4'b0011, 4'b0000);
    set_req(1, 4'b0001, 4'b0001, 4'b0010);
    wait_rsp(lat);
    check("bp_latency", 32'(lat), 32'd2);
    hold = s_rsp;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_stable", 32'(s_rsp), 32'(hold));
      check("bp_ready_low", 32'(s_rdy), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    tick();
    check("bp_next_accept", 32'(acc_port), 32'd1);

    // asynchronous reset during ISSUE
    req_valid = 2'b11;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_async", 32'({req_ready, rsp_valid, alu_sel}), 32'd0);
    @(negedge clk);
    check("mid_rst_next", 32'({req_ready, rsp_valid, alu_sel}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    tick();
    check("post_rst_grant", 32'(acc_port), 32'd0);

    // randomized traffic
    rand_on = 1;
    for (int i = 0; i < 3000; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
